regfile_dump_reader: RTL and testbench

//  Debug/trace reader for the 32x32 CPU register file. On a Start pulse it walks

---
 rtl/regfile_dump_reader_pkg.sv | 8 +
 rtl/regfile_dump_reader.sv | 91 +++++++++
 tb/tb_regfile_dump_reader.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_reader_pkg.sv
// regfile_dump_reader_pkg: register-file geometry shared with the datapath, plus the
// state encoding of the dump reader.
package regfile_dump_reader_pkg;
    localparam int REG_AW = 5;
    localparam int REG_DW = 32;
    localparam int REG_N  = 32;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;
endpackage

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks register indices FIRST..LAST on a spare read port and
// streams {index, value} beats over valid/ready toward a trace sink.
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int AW    = REG_AW,
    parameter int DW    = REG_DW,
    parameter int FIRST = 0,
    parameter int LAST  = REG_N - 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          abort_i,
    output logic [AW-1:0] ra_o,
    input  logic [DW-1:0] qa_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [AW-1:0] out_idx_o,
    output logic [DW-1:0] out_data_o,
    output logic          busy_o,
    output logic          done_o
);
    localparam logic [AW-1:0] FIRST_A = AW'(FIRST);
    localparam logic [AW-1:0] LAST_A  = AW'(LAST);

    state_e        state_q;
    logic [AW-1:0] ptr_q;
    logic [AW-1:0] idx_q;
    logic [DW-1:0] data_q;
    logic          valid_q;
    logic          done_q;
    logic          start_q;
    logic          load_d;
    logic          hs_d;

    assign load_d = !valid_q || out_ready_i;
    assign hs_d   = valid_q && out_ready_i;

    // start_q registers the request so the first beat appears two edges after Start
    always_ff @(posedge clk_i) begin
        done_q <= 1'b0;
        if (rst_i) begin
            state_q <= S_IDLE;
            ptr_q   <= FIRST_A;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
        end else if (abort_i && state_q != S_IDLE) begin
            state_q <= S_IDLE;
            ptr_q   <= FIRST_A;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_q) begin
                        state_q <= S_RUN;
                        ptr_q   <= FIRST_A;
                    end
                    start_q <= start_i && !abort_i && !start_q;
                end
                S_RUN: begin
                    if (load_d) begin
                        data_q  <= qa_i;
                        idx_q   <= ptr_q;
                        valid_q <= 1'b1;
                        if (ptr_q == LAST_A) state_q <= S_DRAIN;
                        else ptr_q <= ptr_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (hs_d) begin
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                        ptr_q   <= FIRST_A;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ra_o        = ptr_q;
    assign out_valid_o = valid_q;
    assign out_idx_o   = idx_q;
    assign out_data_o  = data_q;
    assign busy_o      = state_q != S_IDLE;
    assign done_o      = done_q;
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: directed scenarios for the dump reader against a behavioural
// register file with posedge writes and a hardwired zero register.
module tb_regfile_dump_reader;
    logic        clk = 1'b0;
    logic        rst, start, abort, ready, valid, busy, done;
    logic [4:0]  ra, idx;
    logic [31:0] qa, data;
    logic        start2, ready2, valid2, busy2, done2;
    logic [4:0]  ra2, idx2;
    logic [31:0] qa2, data2;
    logic        init, we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] rf [32];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (init) for (int i = 0; i < 32; i++) rf[i] <= 32'hA500_0000 + 32'(i);
        else if (we) rf[wa] <= wd;
    end
    assign qa  = (ra == 5'd0) ? 32'h0 : rf[ra];
    assign qa2 = (ra2 == 5'd0) ? 32'h0 : rf[ra2];

    regfile_dump_reader dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
        .ra_o(ra), .qa_i(qa), .out_valid_o(valid), .out_ready_i(ready),
        .out_idx_o(idx), .out_data_o(data), .busy_o(busy), .done_o(done)
    );

    regfile_dump_reader #(.FIRST(7), .LAST(7)) dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start2), .abort_i(1'b0),
        .ra_o(ra2), .qa_i(qa2), .out_valid_o(valid2), .out_ready_i(ready2),
        .out_idx_o(idx2), .out_data_o(data2), .busy_o(busy2), .done_o(done2)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ev(input int i);
        return (i == 0) ? 32'h0 : 32'hA500_0000 + 32'(i);
    endfunction

    task automatic test_reset;
        rst = 1'b1; init = 1'b1;
        step; step;
        init = 1'b0;
        step;
        checks++; if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_ctrl: valid=%b busy=%b done=%b want 0 0 0", valid, busy, done); end
        checks++; if (idx !== 5'd0 || data !== 32'h0) begin errors++; $display("FAIL reset_beat: idx=%0d data=%h want 0 0", idx, data); end
        checks++; if (ra !== 5'd0 || ra2 !== 5'd7) begin errors++; $display("FAIL reset_ra: ra=%0d ra2=%0d want 0 7", ra, ra2); end
        rst = 1'b0;
        step;
        checks++; if (valid2 !== 1'b0 || busy2 !== 1'b0) begin errors++; $display("FAIL reset_dut2: valid2=%b busy2=%b want 0 0", valid2, busy2); end
    endtask

    task automatic test_full_dump;
        int bad = 0;
        ready = 1'b1; start = 1'b1;
        step;
        start = 1'b0;
        step;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL full_latency: valid=%b want 0 one edge after start", valid); end
        for (int i = 0; i < 32; i++) begin
            step;
            if (valid !== 1'b1 || idx !== 5'(i) || data !== ev(i)) begin
                bad++;
                $display("FAIL full_beat: valid=%b idx=%0d data=%h want 1 %0d %h", valid, idx, data, i, ev(i));
            end
        end
        checks++; if (bad != 0) errors++;
        step;
        checks++; if (done !== 1'b1 || busy !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL full_done: done=%b busy=%b valid=%b want 1 0 0", done, busy, valid); end
        step;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL full_done_pulse: done=%b want 0", done); end
    endtask

    task automatic test_backpressure;
        int n = 0;
        logic pv, pr;
        logic [4:0] pi;
        logic [31:0] pd;
        start = 1'b1;
        step;
        start = 1'b0;
        for (int k = 0; k < 400 && n < 32; k++) begin
            ready = (k % 4 == 0) || (k % 4 == 3);
            pv = valid; pr = ready; pi = idx; pd = data;
            if (pv && pr) begin
                checks++; if (pi !== 5'(n) || pd !== ev(n)) begin errors++; $display("FAIL bp_order: idx=%0d data=%h want %0d %h", pi, pd, n, ev(n)); end
                n++;
            end
            step;
            if (pv && !pr) begin
                checks++; if (valid !== 1'b1 || idx !== pi || data !== pd) begin errors++; $display("FAIL bp_stable: valid=%b idx=%0d data=%h want 1 %0d %h", valid, idx, data, pi, pd); end
            end
        end
        checks++; if (n != 32 || done !== 1'b1) begin errors++; $display("FAIL bp_done: beats=%0d done=%b want 32 1", n, done); end
        ready = 1'b1;
        step;
    endtask

    task automatic test_abort;
        int t;
        ready = 1'b1; start = 1'b1;
        step;
        start = 1'b0;
        for (t = 0; t < 60; t++) begin
            step;
            if (valid && idx == 5'd10) break;
        end
        ready = 1'b0;
        step;
        checks++; if (valid !== 1'b1 || idx !== 5'd10) begin errors++; $display("FAIL abort_stall: valid=%b idx=%0d want 1 10", valid, idx); end
        abort = 1'b1;
        step;
        abort = 1'b0;
        checks++; if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_cancel: valid=%b busy=%b done=%b want 0 0 0", valid, busy, done); end
        step;
        checks++; if (done !== 1'b0 || busy !== 1'b0 || ra !== 5'd0) begin errors++; $display("FAIL abort_idle: done=%b busy=%b ra=%0d want 0 0 0", done, busy, ra); end
        abort = 1'b1; start = 1'b1;
        step;
        abort = 1'b0; start = 1'b0;
        step; step; step;
        checks++; if (busy !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL abort_start_idle: busy=%b valid=%b want 0 0", busy, valid); end
        ready = 1'b1; start = 1'b1;
        step;
        start = 1'b0;
        step; step;
        checks++; if (valid !== 1'b1 || idx !== 5'd0 || data !== 32'h0) begin errors++; $display("FAIL abort_restart: valid=%b idx=%0d data=%h want 1 0 0", valid, idx, data); end
        for (t = 0; t < 40 && done !== 1'b1; t++) step;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL abort_redrain: done=%b want 1 within 40 cycles", done); end
        step;
    endtask

    task automatic test_write_race;
        for (int c = 0; c < 2; c++) begin
            logic [31:0] want;
            int wr_edge, bad;
            want    = (c == 0) ? 32'hA500_0005 : 32'hDEAD_BEEF;
            wr_edge = (c == 0) ? 5 : 4;
            bad     = 0;
            wa = 5'd5; wd = 32'hA500_0005; we = 1'b1;
            step;
            we = 1'b0; ready = 1'b1; start = 1'b1;
            step;
            start = 1'b0;
            step;
            for (int i = 0; i < 32; i++) begin
                we = (i == wr_edge); wd = 32'hDEAD_BEEF;
                step;
                we = 1'b0;
                if (idx !== 5'(i)) bad++;
                if (i == 5) begin
                    checks++; if (valid !== 1'b1 || data !== want) begin errors++; $display("FAIL race_beat5: case=%0d data=%h want %h", c, data, want); end
                end
            end
            checks++; if (bad != 0) begin errors++; $display("FAIL race_order: case=%0d index errors=%0d want 0", c, bad); end
            step;
            checks++; if (done !== 1'b1) begin errors++; $display("FAIL race_done: case=%0d done=%b want 1", c, done); end
        end
    endtask

    task automatic test_first_last;
        int nd = 0, nb = 0, bad = 0;
        wa = 5'd7; wd = 32'h1234_5678; we = 1'b1;
        step;
        we = 1'b0; ready2 = 1'b1; start2 = 1'b1;
        step;
        start2 = 1'b0;
        step;
        checks++; if (valid2 !== 1'b0) begin errors++; $display("FAIL fl_latency: valid2=%b want 0", valid2); end
        step;
        checks++; if (valid2 !== 1'b1 || idx2 !== 5'd7 || data2 !== 32'h1234_5678 || busy2 !== 1'b1) begin errors++; $display("FAIL fl_beat: valid2=%b idx2=%0d data2=%h busy2=%b want 1 7 12345678 1", valid2, idx2, data2, busy2); end
        step;
        checks++; if (done2 !== 1'b1 || valid2 !== 1'b0 || busy2 !== 1'b0) begin errors++; $display("FAIL fl_done: done2=%b valid2=%b busy2=%b want 1 0 0", done2, valid2, busy2); end
        step;
        checks++; if (done2 !== 1'b0) begin errors++; $display("FAIL fl_done_pulse: done2=%b want 0", done2); end
        start2 = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step;
            if (valid2) begin nb++; if (idx2 !== 5'd7) bad++; end
            if (done2) nd++;
        end
        start2 = 1'b0;
        checks++; if (nb != 10 || nd != 10 || bad != 0) begin errors++; $display("FAIL fl_held_start: beats=%0d dones=%0d badidx=%0d want 10 10 0", nb, nd, bad); end
        step; step;
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL fl_idle_after: busy2=%b want 0", busy2); end
    endtask

    task automatic test_rst_drain;
        ready = 1'b1; start = 1'b1;
        step;
        start = 1'b0;
        for (int t = 0; t < 60; t++) begin
            step;
            if (valid && idx == 5'd31) break;
        end
        ready = 1'b0;
        step;
        checks++; if (busy !== 1'b1 || valid !== 1'b1 || idx !== 5'd31) begin errors++; $display("FAIL rst_drain_hold: busy=%b valid=%b idx=%0d want 1 1 31", busy, valid, idx); end
        rst = 1'b1;
        step;
        rst = 1'b0;
        checks++; if (valid !== 1'b0 || idx !== 5'd0 || data !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || ra !== 5'd0) begin
            errors++; $display("FAIL rst_drain_clear: valid=%b idx=%0d data=%h busy=%b done=%b ra=%0d want all 0", valid, idx, data, busy, done, ra);
        end
        step;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_drain_after: done=%b busy=%b want 0 0", done, busy); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b0;
        start2 = 1'b0; ready2 = 1'b0; init = 1'b0; we = 1'b0; wa = 5'd0; wd = 32'h0;
        test_reset;
        test_full_dump;
        test_backpressure;
        test_abort;
        test_write_race;
        test_first_last;
        test_rst_drain;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 time units");
        $fatal(1);
    end
endmodule
